sampler_scheduler: RTL and testbench
====================================

Name: sampler_scheduler

Overview:
- Round-robin scheduler that shares one Sampler (depth 32, back/front strobe offsets) between NREQ requesters.
- Each request names a direction (history or future) and a 5-bit offset.
- The block drives the sampler's STRB, SHIFT, STRB_BACK and STRB_FRONT, and holds that configuration stable while a future sample is pending.
- It captures SAMP_DATA/SAMP_VALID at the computed cycle and returns the result, tagged with the requester ID, over a valid/ready response port.

Parameters:
- NREQ, 4, number of requesters.
- IDW, 2, requester ID width; NREQ <= 2**IDW required.

Ports:
- CLK  in  1  clock; single clock domain.
- RST  in  1  reset, synchronous, active-high.
- REQ_VALID  in  NREQ  per-requester request; held with DIR/OFS stable until REQ_READY.
- REQ_DIR  in  NREQ  per-requester direction: 0 = history (back), 1 = future (front).
- REQ_OFS  in  5*NREQ  per-requester offset 0..31; requester i uses bits [5i+4:5i].
- REQ_READY  out  NREQ  one-cycle accept pulse, one-hot.
- STRB  out  1  sampler strobe, one-cycle pulse.
- SHIFT  out  1  sampler direction.
- STRB_BACK  out  5  sampler history offset.
- STRB_FRONT  out  5  sampler future offset.
- SAMP_DATA  in  8  sampler data.
- SAMP_VALID  in  1  sampler data-valid; this is the DQ valid bit, not a capture strobe.
- RSP_VALID  out  1  response available.
- RSP_READY  in  1  response consumed.
- RSP_ID  out  IDW  requester ID of the response.
- RSP_DATA  out  8  captured SAMP_DATA.
- RSP_DVALID  out  1  captured SAMP_VALID.
- BUSY  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset values: all outputs 0.
  - FSM = IDLE, round-robin pointer last = NREQ-1, so requester 0 has top priority.
  - Reset in any state aborts the transaction: no response, STRB low on the next cycle.
- FSM states: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
- IDLE:
  - If any REQ_VALID is set, grant g = first set requester searching last+1, last+2, ... (mod NREQ).
  - On the clock edge, latch id = g, dir, ofs, set last = g, and go to ISSUE.
  - If no request, stay in IDLE.
- ISSUE (exactly 1 cycle):
  - STRB = 1, REQ_READY[g] = 1.
  - SHIFT = dir; STRB_BACK = dir ? 0 : ofs; STRB_FRONT = dir ? ofs : 0.
  - Load wait counter W = (dir && ofs != 0) ? ofs : 0. Go to WAIT.
- WAIT:
  - STRB = 0. SHIFT, STRB_BACK and STRB_FRONT keep the ISSUE values; the sampler's future pipeline depends on them staying stable.
  - If W == 0: capture RSP_DATA = SAMP_DATA, RSP_DVALID = SAMP_VALID, RSP_ID = id, and go to RESP.
  - Otherwise decrement W.
  - Resulting WAIT duration: ofs+1 cycles for a future request with ofs != 0; 1 cycle for back requests and for future with ofs = 0.
- RESP:
  - RSP_VALID = 1; RSP_ID, RSP_DATA and RSP_DVALID held stable.
  - When RSP_READY = 1: go to IDLE, RSP_VALID = 0 next cycle.
  - No arbitration in the handshake cycle.
- SHIFT, STRB_BACK and STRB_FRONT keep their values after WAIT until the next ISSUE.
- Latency: with the grant taken in IDLE cycle c0, REQ_READY and STRB are high in c0+1 and RSP_VALID is first high in c0+3+W0, where W0 is the loaded W.
- Throughput: at most one sampler transaction in flight; a new STRB never issues before the previous response is accepted.
- SAMP_* changes outside the capture cycle are ignored, including stray outputs after a reset mid-operation.
- Simultaneous requests: exactly one grant per IDLE cycle. Ungranted requesters keep REQ_VALID asserted and see no REQ_READY.
- Offsets are not range-checked. A back offset larger than the history written since sampler reset returns RSP_DVALID = 0 from the sampler's cleared history.

Test Plan:
- Bench setup: DQ_OUT = free-running 8-bit cycle count, DQ_OUT_VALID = 1. Requester 0 issues back ofs=3 with STRB in cycle T. Required: RSP_DATA = T-3, RSP_DVALID = 1, RSP_ID = 0, RSP_VALID first high at T+2.
- Requester 1 issues future ofs=5 with STRB in cycle T. Required: SHIFT = 1 and STRB_FRONT = 5 stable for cycles T..T+6, RSP_DATA = T+5, RSP_VALID at T+7.
- Back ofs=0 and future ofs=0, each from its own request. Required: both return RSP_DATA = T (the STRB cycle), RSP_VALID at T+2.
- All 4 REQ_VALID held high with RSP_READY = 1. Required: grant order 0,1,2,3,0; REQ_READY one-hot; spacing between STRB pulses = 4+W0 cycles.
- RSP_READY held low for 10 cycles during RESP with other requests pending. Required: RSP_* stable, no STRB, no REQ_READY; IDLE one cycle after RSP_READY is asserted.
- RST asserted during WAIT of a future ofs=20 request. Required: all outputs 0 next cycle, no RSP_VALID, a stray sampler output ignored, requester 0 granted first after reset.

Source files
------------

// File: rtl/sampler_scheduler.sv
// Round-robin scheduler sharing one depth-32 Sampler between NREQ requesters.
// Ports: REQ_* per-requester request/accept, STRB/SHIFT/STRB_BACK/STRB_FRONT
//   sampler config, SAMP_* sampler data, RSP_* tagged response, BUSY = not idle.
module sampler_scheduler #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [NREQ-1:0]   REQ_VALID,
    input  logic [NREQ-1:0]   REQ_DIR,
    input  logic [5*NREQ-1:0] REQ_OFS,
    output logic [NREQ-1:0]   REQ_READY,
    output logic              STRB,
    output logic              SHIFT,
    output logic [4:0]        STRB_BACK,
    output logic [4:0]        STRB_FRONT,
    input  logic [7:0]        SAMP_DATA,
    input  logic              SAMP_VALID,
    output logic              RSP_VALID,
    input  logic              RSP_READY,
    output logic [IDW-1:0]    RSP_ID,
    output logic [7:0]        RSP_DATA,
    output logic              RSP_DVALID,
    output logic              BUSY
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    state_t         state_q, state_d;
    logic [IDW-1:0] last_q, last_d;
    logic [IDW-1:0] id_q, id_d;
    logic           shift_q, shift_d;
    logic [4:0]     back_q, back_d;
    logic [4:0]     front_q, front_d;
    logic [4:0]     w_q, w_d;
    logic [IDW-1:0] rid_q, rid_d;
    logic [7:0]     rdata_q, rdata_d;
    logic           rdv_q, rdv_d;

    logic           gnt_found;
    int             gnt_i;
    logic           dir_sel;
    logic [4:0]     ofs_sel;

    // Rotating priority: search last+1, last+2, ... (mod NREQ).
    always_comb begin
        gnt_found = 1'b0;
        gnt_i     = 0;
        dir_sel   = 1'b0;
        ofs_sel   = 5'd0;
        for (int k = 1; k <= NREQ; k++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!gnt_found && REQ_VALID[i] &&
                    i == (int'(last_q) + k) % NREQ) begin
                    gnt_found = 1'b1;
                    gnt_i     = i;
                    dir_sel   = REQ_DIR[i];
                    ofs_sel   = REQ_OFS[5*i +: 5];
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            last_q  <= IDW'(NREQ - 1);
            id_q    <= '0;
            shift_q <= 1'b0;
            back_q  <= 5'd0;
            front_q <= 5'd0;
            w_q     <= 5'd0;
            rid_q   <= '0;
            rdata_q <= 8'd0;
            rdv_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            id_q    <= id_d;
            shift_q <= shift_d;
            back_q  <= back_d;
            front_q <= front_d;
            w_q     <= w_d;
            rid_q   <= rid_d;
            rdata_q <= rdata_d;
            rdv_q   <= rdv_d;
        end
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        id_d    = id_q;
        shift_d = shift_q;
        back_d  = back_q;
        front_d = front_q;
        w_d     = w_q;
        rid_d   = rid_q;
        rdata_d = rdata_q;
        rdv_d   = rdv_q;
        unique case (state_q)
            IDLE: begin
                if (gnt_found) begin
                    id_d   = IDW'(gnt_i);
                    last_d = IDW'(gnt_i);
                    // Config loads on the grant edge so it is already
                    // valid in the ISSUE cycle alongside STRB.
                    shift_d = dir_sel;
                    back_d  = dir_sel ? 5'd0 : ofs_sel;
                    front_d = dir_sel ? ofs_sel : 5'd0;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                // front_q is ofs for future requests and 0 otherwise.
                w_d     = front_q;
                state_d = WAIT;
            end
            WAIT: begin
                if (w_q == 5'd0) begin
                    rid_d   = id_q;
                    rdata_d = SAMP_DATA;
                    rdv_d   = SAMP_VALID;
                    state_d = RESP;
                end else begin
                    w_d = w_q - 5'd1;
                end
            end
            RESP: begin
                if (RSP_READY) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            REQ_READY[i] = (state_q == ISSUE) && (int'(id_q) == i);
        end
    end

    assign STRB       = (state_q == ISSUE);
    assign SHIFT      = shift_q;
    assign STRB_BACK  = back_q;
    assign STRB_FRONT = front_q;
    assign RSP_VALID  = (state_q == RESP);
    assign RSP_ID     = rid_q;
    assign RSP_DATA   = rdata_q;
    assign RSP_DVALID = rdv_q;
    assign BUSY       = (state_q != IDLE);

endmodule

// File: tb/tb_sampler_scheduler.sv
// Scoreboard bench for sampler_scheduler with a behavioural sampler model.
// Sampler source data is the free-running cycle count.
module tb_sampler_scheduler;

    logic        CLK = 1'b0;
    logic        RST;
    logic [3:0]  REQ_VALID;
    logic [3:0]  REQ_DIR;
    logic [19:0] REQ_OFS;
    logic [3:0]  REQ_READY;
    logic        STRB;
    logic        SHIFT;
    logic [4:0]  STRB_BACK;
    logic [4:0]  STRB_FRONT;
    logic [7:0]  SAMP_DATA;
    logic        SAMP_VALID;
    logic        RSP_VALID;
    logic        RSP_READY;
    logic [1:0]  RSP_ID;
    logic [7:0]  RSP_DATA;
    logic        RSP_DVALID;
    logic        BUSY;

    sampler_scheduler #(.NREQ(4), .IDW(2)) dut (
        .CLK(CLK), .RST(RST),
        .REQ_VALID(REQ_VALID), .REQ_DIR(REQ_DIR), .REQ_OFS(REQ_OFS),
        .REQ_READY(REQ_READY), .STRB(STRB), .SHIFT(SHIFT),
        .STRB_BACK(STRB_BACK), .STRB_FRONT(STRB_FRONT),
        .SAMP_DATA(SAMP_DATA), .SAMP_VALID(SAMP_VALID),
        .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY), .RSP_ID(RSP_ID),
        .RSP_DATA(RSP_DATA), .RSP_DVALID(RSP_DVALID), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int         id;
        logic [7:0] data;
        int         cyc;
    } exp_t;

    typedef struct {
        int id;
        int t;
    } gnt_t;

    exp_t        sbq[$];
    gnt_t        glog[$];
    exp_t        cur;
    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    logic [10:0] exp_cfg = '0;
    bit          seen    = 0;
    bit          hs_prev = 0;
    bit          pend    = 0;
    int          tgt     = 0;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    always @(posedge CLK) cyc <= cyc + 1;

    // Sampler model: back strobe returns count-ofs next cycle, future
    // strobe returns count at T+ofs one cycle later; otherwise junk.
    always @(posedge CLK) begin
        SAMP_DATA  <= 8'hA5;
        SAMP_VALID <= 1'b0;
        if (pend && cyc == tgt) begin
            SAMP_DATA  <= 8'(cyc);
            SAMP_VALID <= 1'b1;
            pend       <= 1'b0;
        end
        if (STRB) begin
            if (!SHIFT) begin
                SAMP_DATA  <= 8'(cyc - int'(STRB_BACK));
                SAMP_VALID <= 1'b1;
            end else if (STRB_FRONT == 5'd0) begin
                SAMP_DATA  <= 8'(cyc);
                SAMP_VALID <= 1'b1;
            end else begin
                pend <= 1'b1;
                tgt  <= cyc + int'(STRB_FRONT);
            end
        end
    end

    task automatic req(int id, bit dir, int ofs);
        bit   got = 0;
        int   t;
        exp_t e;
        @(negedge CLK);
        REQ_DIR[id]        = dir;
        REQ_OFS[5*id +: 5] = 5'(ofs);
        REQ_VALID[id]      = 1'b1;
        for (int i = 0; i < 300 && !got; i++) begin
            @(negedge CLK);
            if (REQ_READY[id]) got = 1;
        end
        if (!got) begin
            chk("req_timeout", 32'(id), 32'hFF);
            REQ_VALID[id] = 1'b0;
            return;
        end
        t = cyc;
        chk("issue_strb", 32'(STRB), 32'd1);
        chk("issue_onehot", 32'($onehot(REQ_READY)), 32'd1);
        exp_cfg = {dir, dir ? 5'd0 : 5'(ofs), dir ? 5'(ofs) : 5'd0};
        chk("issue_cfg", 32'({SHIFT, STRB_BACK, STRB_FRONT}), 32'(exp_cfg));
        e.id   = id;
        e.data = dir ? 8'(t + ofs) : 8'(t - ofs);
        e.cyc  = t + 2 + (dir ? ofs : 0);
        sbq.push_back(e);
        glog.push_back('{id, t});
        @(posedge CLK);
        #1 REQ_VALID[id] = 1'b0;
    endtask

    // Monitor: pops the scoreboard on each new response and checks
    // stability, handshake timing and config hold.
    always @(negedge CLK) begin
        if (!RST) begin
            if (hs_prev) begin
                chk("idle_after_hs", 32'({BUSY, RSP_VALID}), 32'd0);
                hs_prev = 0;
            end
            if (STRB || REQ_READY != 4'd0)
                chk("strb_ready_pair", 32'({STRB, $onehot(REQ_READY)}), 32'd3);
            if (!STRB)
                chk("cfg_hold", 32'({SHIFT, STRB_BACK, STRB_FRONT}),
                    32'(exp_cfg));
            if (RSP_VALID) begin
                chk("rsp_no_issue", 32'({STRB, |REQ_READY}), 32'd0);
                if (!seen) begin
                    if (sbq.size() == 0) begin
                        chk("unexpected_rsp", 32'(RSP_ID), 32'hFF);
                        cur = '{-1, 8'h00, -1};
                    end else begin
                        cur = sbq.pop_front();
                        chk("rsp_id", 32'(RSP_ID), 32'(cur.id));
                        chk("rsp_data", 32'(RSP_DATA), 32'(cur.data));
                        chk("rsp_dvalid", 32'(RSP_DVALID), 32'd1);
                        chk("rsp_latency", 32'(cyc), 32'(cur.cyc));
                    end
                    seen = 1;
                end else begin
                    chk("rsp_stable", 32'({RSP_ID, RSP_DATA, RSP_DVALID}),
                        32'({2'(cur.id), cur.data, 1'b1}));
                end
                if (RSP_READY) begin
                    seen    = 0;
                    hs_prev = 1;
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit got;
        RST       = 1'b1;
        REQ_VALID = '0;
        REQ_DIR   = '0;
        REQ_OFS   = '0;
        RSP_READY = 1'b1;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        chk("reset_outputs",
            32'({REQ_READY, STRB, SHIFT, STRB_BACK, STRB_FRONT,
                 RSP_VALID, RSP_ID, RSP_DATA, RSP_DVALID, BUSY}), 32'd0);
        @(posedge CLK);
        #1 RST = 1'b0;

        // Back ofs=3, future ofs=5, then both zero offsets.
        req(0, 1'b0, 3);
        req(1, 1'b1, 5);
        req(2, 1'b0, 0);
        req(3, 1'b1, 0);

        // Round robin with all requesters pending.
        repeat (8) @(negedge CLK);
        glog.delete();
        fork
            begin
                req(0, 1'b0, 1);
                req(0, 1'b0, 6);
            end
            req(1, 1'b0, 7);
            req(2, 1'b0, 2);
            req(3, 1'b0, 9);
        join
        chk("rr_count", 32'(glog.size()), 32'd5);
        if (glog.size() == 5) begin
            chk("rr_g0", 32'(glog[0].id), 32'd0);
            chk("rr_g1", 32'(glog[1].id), 32'd1);
            chk("rr_g2", 32'(glog[2].id), 32'd2);
            chk("rr_g3", 32'(glog[3].id), 32'd3);
            chk("rr_g4", 32'(glog[4].id), 32'd0);
            for (int i = 0; i < 4; i++)
                chk("rr_spacing", 32'(glog[i+1].t - glog[i].t), 32'd4);
        end

        // Backpressure with another request pending.
        repeat (8) @(negedge CLK);
        fork
            req(2, 1'b0, 4);
            req(3, 1'b1, 2);
            begin
                @(posedge CLK);
                #1 RSP_READY = 1'b0;
                got = 0;
                for (int i = 0; i < 100 && !got; i++) begin
                    @(negedge CLK);
                    if (RSP_VALID) got = 1;
                end
                if (!got) chk("bp_timeout", 32'd0, 32'd1);
                repeat (10) @(negedge CLK);
                @(posedge CLK);
                #1 RSP_READY = 1'b1;
            end
        join

        // Reset during WAIT of a future ofs=20 request.
        repeat (12) @(negedge CLK);
        req(1, 1'b1, 20);
        repeat (3) @(posedge CLK);
        #1 RST = 1'b1;
        @(posedge CLK);
        #1 RST = 1'b0;
        exp_cfg = '0;
        sbq.delete();
        @(negedge CLK);
        chk("abort_outputs",
            32'({REQ_READY, STRB, SHIFT, STRB_BACK, STRB_FRONT,
                 RSP_VALID, RSP_ID, RSP_DATA, RSP_DVALID, BUSY}), 32'd0);
        glog.delete();
        fork
            req(1, 1'b0, 1);
            req(0, 1'b0, 2);
        join
        chk("post_rst_count", 32'(glog.size()), 32'd2);
        if (glog.size() == 2) begin
            chk("post_rst_first", 32'(glog[0].id), 32'd0);
            chk("post_rst_second", 32'(glog[1].id), 32'd1);
        end

        repeat (30) @(negedge CLK);
        chk("sb_drained", 32'(sbq.size()), 32'd0);
        chk("final_idle", 32'({BUSY, RSP_VALID}), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
